burst_rd_ctrl: RTL and testbench

Burst read controller that sits directly upstream of the registered read stage. It turns a single `{base, length}` command into a stream of one-word read requests on consecutive addresses. It collects the returned words, in order, into an internal first-word-fall-through FIFO and presents them downstream on a valid/ready handshake. Credit-based issue guarantees the FIFO can never overflow, whatever the read-path latency.

---
 rtl/burst_rd_pkg.sv | 23 ++
 rtl/rd_fifo.sv | 61 ++++++
 rtl/burst_rd_ctrl.sv | 152 +++++++++++++++
 tb/tb_burst_rd_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_rd_pkg.sv
`default_nettype none
// ==========================================================================
// burst_rd_pkg: shared FSM state encoding and counter-width helpers.  Rev 1.0
// ==========================================================================
package burst_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int FIFO_DEPTH_DFLT = 4;
  localparam int CNT_W           = $clog2(FIFO_DEPTH_DFLT) + 1;

  // Width that holds 0..depth inclusive, for non-default FIFO depths.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rd_fifo.sv
`default_nettype none
// ==========================================================================
// rd_fifo: synchronous first-word-fall-through return buffer.  Rev 1.0
// ==========================================================================
module rd_fifo
  import burst_rd_pkg::*;
#(
  parameter int SIZE_DATA  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_push,
  input  logic [SIZE_DATA-1:0]                i_push_data,
  input  logic                                i_pop,
  output logic [cnt_width(FIFO_DEPTH)-1:0]    o_count,
  output logic                                o_empty,
  output logic                                o_full,
  output logic [SIZE_DATA-1:0]                o_head
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = cnt_width(FIFO_DEPTH);

  logic [SIZE_DATA-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;
  logic                 w_push_ok;
  logic                 w_pop_ok;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == c_cnt_w'(FIFO_DEPTH));
  assign o_count = r_count;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push_ok = i_push && (!o_full || i_pop);
  assign w_pop_ok  = i_pop && !o_empty;

  assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      r_count <= r_count + c_cnt_w'(w_push_ok) - c_cnt_w'(w_pop_ok);
    end
  end

endmodule
`default_nettype wire

// File: rtl/burst_rd_ctrl.sv
`default_nettype none
// ==========================================================================
// burst_rd_ctrl: credit-limited burst reader feeding an FWFT return buffer.  Rev 1.0
// ==========================================================================
module burst_rd_ctrl
  import burst_rd_pkg::*;
#(
  parameter int SIZE_ADDR  = 8,
  parameter int SIZE_DATA  = 8,
  parameter int SIZE_LEN   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [SIZE_ADDR-1:0] i_base_addr,
  input  logic [SIZE_LEN-1:0]  i_len,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic                 o_rd_en,
  output logic [SIZE_ADDR-1:0] o_addr_rd,
  input  logic                 i_valid,
  input  logic [SIZE_DATA-1:0] i_data_rd,
  output logic [SIZE_DATA-1:0] o_data,
  output logic                 o_data_valid,
  input  logic                 i_data_ready
);

  localparam int c_cnt_w = cnt_width(FIFO_DEPTH);
  localparam int c_sum_w = c_cnt_w + 1;

  state_e               r_state;
  state_e               w_state_nxt;
  logic [SIZE_ADDR-1:0] r_addr_q;
  logic [SIZE_LEN-1:0]  r_remaining;
  logic [SIZE_LEN-1:0]  r_popped;
  logic [SIZE_LEN-1:0]  r_len_q;
  logic [c_cnt_w-1:0]   r_outstanding;
  logic                 r_err;
  logic                 r_rd_en;
  logic [SIZE_ADDR-1:0] r_addr_rd;

  logic [c_cnt_w-1:0]   w_fifo_count;
  logic                 w_fifo_empty;
  logic                 w_fifo_full;
  logic [c_sum_w-1:0]   w_inflight;
  logic                 w_credit_ok;
  logic                 w_issue;
  logic                 w_start;
  logic                 w_ret_ok;
  logic                 w_stray;
  logic                 w_pop;
  logic [SIZE_LEN-1:0]  w_popped_nxt;

  assign w_start  = (r_state == IDLE) && i_start;
  assign w_pop    = o_data_valid && i_data_ready;
  assign w_ret_ok = i_valid && (r_outstanding != '0);
  assign w_stray  = i_valid && (r_outstanding == '0);

  // Every word in flight owns a FIFO slot, so returns can never overflow it.
  assign w_inflight  = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  assign w_credit_ok = !w_fifo_full && (w_inflight < c_sum_w'(FIFO_DEPTH));
  assign w_issue     = (r_state == ISSUE) && (r_remaining != '0) && w_credit_ok;

  assign w_popped_nxt = r_popped + SIZE_LEN'(w_pop);

  rd_fifo #(
    .SIZE_DATA  (SIZE_DATA),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_rd_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_ret_ok),
    .i_push_data (i_data_rd),
    .i_pop       (w_pop),
    .o_count     (w_fifo_count),
    .o_empty     (w_fifo_empty),
    .o_full      (w_fifo_full),
    .o_head      (o_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) w_state_nxt = (i_len != '0) ? ISSUE : DONE;
      end
      ISSUE: begin
        if (w_issue && (r_remaining == SIZE_LEN'(1))) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        // Look ahead at this cycle's pop so DONE follows the last pop directly.
        if (w_popped_nxt == r_len_q) w_state_nxt = DONE;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr_q      <= '0;
      r_remaining   <= '0;
      r_popped      <= '0;
      r_len_q       <= '0;
      r_outstanding <= '0;
      r_err         <= 1'b0;
      r_rd_en       <= 1'b0;
      r_addr_rd     <= '0;
    end else begin
      r_rd_en       <= w_issue;
      r_outstanding <= r_outstanding + c_cnt_w'(w_issue) - c_cnt_w'(w_ret_ok);
      if (w_issue) r_addr_rd <= r_addr_q;
      if (w_start) begin
        r_addr_q    <= i_base_addr;
        r_remaining <= i_len;
        r_len_q     <= i_len;
        r_popped    <= '0;
        r_err       <= w_stray;
      end else begin
        if (w_issue) begin
          r_addr_q    <= r_addr_q + SIZE_ADDR'(1);
          r_remaining <= r_remaining - SIZE_LEN'(1);
        end
        r_popped <= w_popped_nxt;
        if (w_stray) r_err <= 1'b1;
      end
    end
  end

  assign o_busy       = (r_state != IDLE);
  assign o_done       = (r_state == DONE);
  assign o_err        = r_err;
  assign o_rd_en      = r_rd_en;
  assign o_addr_rd    = r_addr_rd;
  assign o_data_valid = !w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_burst_rd_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_burst_rd_ctrl: directed vector bench with an in-order read-stage model.  Rev 1.0
// ==========================================================================
module tb_burst_rd_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0;
  logic [7:0] i_base_addr = '0;
  logic [7:0] i_len = '0;
  logic       o_busy, o_done, o_err, o_rd_en, o_data_valid;
  logic [7:0] o_addr_rd, o_data;
  logic       i_valid = 1'b0;
  logic [7:0] i_data_rd = '0;
  logic       i_data_ready = 1'b0;

  burst_rd_ctrl #(
    .SIZE_ADDR (8), .SIZE_DATA (8), .SIZE_LEN (8), .FIFO_DEPTH (4)
  ) dut (
    .i_clk (i_clk), .i_rst (i_rst), .i_start (i_start),
    .i_base_addr (i_base_addr), .i_len (i_len),
    .o_busy (o_busy), .o_done (o_done), .o_err (o_err),
    .o_rd_en (o_rd_en), .o_addr_rd (o_addr_rd),
    .i_valid (i_valid), .i_data_rd (i_data_rd),
    .o_data (o_data), .o_data_valid (o_data_valid), .i_data_ready (i_data_ready)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] base;
    logic [7:0] len;
    int         lat;
    int         rmode;
    int         exp_n;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vecs[5];

  int n_pass = 0;
  int n_tot  = 0;

  int cyc = 0, issued = 0, popped = 0, done_cnt = 0, done_cyc = -1;
  int last_pop_cyc = -1, max_inflight = 0, lat = 2, rmode = 0;
  bit stray_req = 1'b0;
  logic [7:0] addr_log[$];
  logic [7:0] data_log[$];
  logic [7:0] pend_addr[$];
  int         pend_due[$];

  function automatic logic [7:0] rdf(input logic [7:0] a);
    return {a[3:0], a[7:4]} ^ 8'h3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  // Read stage + downstream sink + monitor in one process: deterministic ordering.
  initial begin
    forever begin
      @(negedge i_clk);
      cyc++;
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (o_rd_en) begin
        pend_addr.push_back(o_addr_rd);
        pend_due.push_back(cyc + lat);
        addr_log.push_back(o_addr_rd);
        issued++;
      end
      if (issued - popped > max_inflight) max_inflight = issued - popped;
      i_valid   = 1'b0;
      i_data_rd = '0;
      if (stray_req) begin
        i_valid   = 1'b1;
        i_data_rd = 8'hEE;
        stray_req = 1'b0;
      end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        i_valid   = 1'b1;
        i_data_rd = rdf(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      i_data_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((cyc % 2) == 0) : 1'b0;
      if (o_data_valid && i_data_ready) begin
        data_log.push_back(o_data);
        popped++;
        last_pop_cyc = cyc;
      end
    end
  end

  task automatic clear_logs();
    addr_log.delete();
    data_log.delete();
    issued = 0; popped = 0; done_cnt = 0; done_cyc = -1;
    last_pop_cyc = -1; max_inflight = 0;
  endtask

  task automatic start_burst(input logic [7:0] base, input logic [7:0] len);
    i_base_addr = base;
    i_len       = len;
    i_start     = 1'b1;
    tick();
    i_start     = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 500 && done_cnt == 0; k++) tick();
    check({name, "_done_seen"}, done_cnt != 0, 1);
    tick();
    tick();
  endtask

  task automatic check_stream(input string name, input logic [7:0] base, input int n);
    int bad_a, bad_d;
    logic [7:0] a;
    bad_a = 0;
    bad_d = 0;
    for (int j = 0; j < addr_log.size(); j++) begin
      a = base + 8'(j);
      if (addr_log[j] !== a) bad_a++;
    end
    for (int j = 0; j < data_log.size(); j++) begin
      a = base + 8'(j);
      if (data_log[j] !== rdf(a)) bad_d++;
    end
    check({name, "_n_words"}, data_log.size(), n);
    check({name, "_addr_seq"}, bad_a, 0);
    check({name, "_data_order"}, bad_d, 0);
  endtask

  initial begin
    vecs[0] = '{8'h10, 8'd3,  2, 0, 3,  8'h12};
    vecs[1] = '{8'hFE, 8'd4,  2, 0, 4,  8'h01};
    vecs[2] = '{8'h40, 8'd6,  5, 1, 6,  8'h45};
    vecs[3] = '{8'h80, 8'd10, 1, 0, 10, 8'h89};
    vecs[4] = '{8'h00, 8'd1,  7, 0, 1,  8'h00};

    // Reset state
    tick(); tick(); tick();
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_err", o_err, 0);
    check("rst_rd_en", o_rd_en, 0);
    check("rst_addr", o_addr_rd, 8'h00);
    check("rst_dvalid", o_data_valid, 0);
    check("rst_data", o_data, 8'h00);
    i_rst = 1'b0;
    tick();

    // Basic burst with cycle-exact issue timing
    lat = 2; rmode = 0;
    clear_logs();
    start_burst(8'h10, 8'd3);
    check("basic_busy", o_busy, 1);
    check("basic_no_early_rd", o_rd_en, 0);
    tick();
    check("basic_rd0", {o_rd_en, o_addr_rd}, {1'b1, 8'h10});
    tick();
    check("basic_rd1", {o_rd_en, o_addr_rd}, {1'b1, 8'h11});
    tick();
    check("basic_rd2", {o_rd_en, o_addr_rd}, {1'b1, 8'h12});
    tick();
    check("basic_rd_stop", o_rd_en, 0);
    wait_done("basic");
    check_stream("basic", 8'h10, 3);
    check("basic_done_pulses", done_cnt, 1);
    check("basic_err", o_err, 0);

    // Table-driven bursts
    foreach (vecs[i]) begin
      lat = vecs[i].lat;
      rmode = vecs[i].rmode;
      clear_logs();
      start_burst(vecs[i].base, vecs[i].len);
      wait_done($sformatf("vec%0d", i));
      check($sformatf("vec%0d_n_req", i), issued, vecs[i].exp_n);
      check($sformatf("vec%0d_last_addr", i), addr_log.size() > 0 ? addr_log[$] : 8'hXX, vecs[i].exp_last);
      check_stream($sformatf("vec%0d", i), vecs[i].base, vecs[i].exp_n);
      check($sformatf("vec%0d_done_pulses", i), done_cnt, 1);
      check($sformatf("vec%0d_done_timing", i), done_cyc - last_pop_cyc, 1);
      check($sformatf("vec%0d_inflight_le4", i), max_inflight <= 4, 1);
      check($sformatf("vec%0d_err", i), o_err, 0);
    end

    // Backpressure: credit caps issue at FIFO_DEPTH
    lat = 2; rmode = 2;
    clear_logs();
    start_burst(8'h50, 8'd10);
    for (int k = 0; k < 15; k++) tick();
    check("bp_issued_cap", issued, 4);
    check("bp_rd_en_low", o_rd_en, 0);
    check("bp_head", {o_data_valid, o_data}, {1'b1, rdf(8'h50)});
    check("bp_busy", o_busy, 1);
    rmode = 0;
    wait_done("bp");
    check_stream("bp", 8'h50, 10);
    check("bp_max_inflight", max_inflight, 4);

    // Zero length
    clear_logs();
    start_burst(8'h33, 8'd0);
    check("zl_done", {o_done, o_busy, o_rd_en}, 3'b110);
    tick();
    check("zl_done_end", {o_done, o_busy}, 2'b00);
    tick();
    check("zl_no_req", issued, 0);

    // Start while busy is ignored
    clear_logs();
    start_burst(8'h40, 8'd5);
    tick();
    i_base_addr = 8'h80; i_len = 8'd2; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_done("busy_start");
    check("busy_start_n_req", issued, 5);
    check_stream("busy_start", 8'h40, 5);
    check("busy_start_done_pulses", done_cnt, 1);

    // Stray return in IDLE
    stray_req = 1'b1;
    tick();
    check("stray_dvalid_0", o_data_valid, 0);
    tick();
    check("stray_err", o_err, 1);
    check("stray_dvalid_1", o_data_valid, 0);
    tick();
    check("stray_err_sticky", o_err, 1);
    clear_logs();
    start_burst(8'h30, 8'd1);
    check("stray_err_cleared", o_err, 0);
    wait_done("stray_after");
    check_stream("stray_after", 8'h30, 1);

    // Reset mid-burst, then late returns
    lat = 3; rmode = 0;
    clear_logs();
    start_burst(8'h20, 8'd8);
    for (int k = 0; k < 50 && issued < 2; k++) tick();
    check("mid_rst_two_issued", issued, 2);
    i_rst = 1'b1;
    tick();
    check("mid_rst_outputs", {o_busy, o_done, o_err, o_rd_en, o_data_valid}, 5'b00000);
    check("mid_rst_addr_data", {o_addr_rd, o_data}, 16'h0000);
    i_rst = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check("mid_rst_late_err", o_err, 1);
    check("mid_rst_dvalid", o_data_valid, 0);
    check("mid_rst_idle", o_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
